// File: rtl/fifo_pkt_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkt_pkg: shared types, default widths and header decode for fifo_pkt_reader
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkt_pkg;

   typedef enum logic {ST_HDR, ST_PAYLOAD} state_t;

   localparam int DEF_BITS     = 8;
   localparam int DEF_LEN_BITS = 8;
   localparam int DEF_CNT_BITS = 16;
   localparam int HDR_MAX_BITS = 64;

   // Keeps only the low len_bits of a header word; callers narrow the result.
   function automatic logic [HDR_MAX_BITS-1:0] hdr_len(input logic [HDR_MAX_BITS-1:0] word,
                                                       input int len_bits);
      logic [HDR_MAX_BITS-1:0] len;
      len = '0;
      for (int i = 0; i < HDR_MAX_BITS; i++) begin
         if (i < len_bits) len[i] = word[i];
      end
      return len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_pkt_reader_stream_reg_slice.sv
//------------------------------------------------------------------------------
// stream_reg_slice: single-entry valid/ready output register with sop/eop framing
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_reg_slice
   import fifo_pkt_pkg::*;
#(
   parameter int pBITS = DEF_BITS
) (
   input  logic             iclk,
   input  logic             ireset,
   input  logic             load,
   input  logic [pBITS-1:0] load_data,
   input  logic             load_sop,
   input  logic             load_eop,
   input  logic             ready,
   output logic [pBITS-1:0] data,
   output logic             valid,
   output logic             sop,
   output logic             eop,
   output logic             slot_free
);

   // The slot frees in the same cycle the held word is accepted.
   assign slot_free = ~valid | ready;

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         data  <= '0;
         valid <= 1'b0;
         sop   <= 1'b0;
         eop   <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
         sop   <= load_sop;
         eop   <= load_eop;
      end else if (slot_free) begin
         valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_pkt_reader.sv
//------------------------------------------------------------------------------
// fifo_pkt_reader: pops length-prefixed packets from a show-ahead FIFO onto a framed stream
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_pkt_reader
   import fifo_pkt_pkg::*;
#(
   parameter int pBITS     = DEF_BITS,
   parameter int pLEN_BITS = DEF_LEN_BITS,
   parameter int pCNT_BITS = DEF_CNT_BITS
) (
   input  logic                 iclk,
   input  logic                 ireset,
   input  logic                 ififo_empty,
   input  logic [pBITS-1:0]     ififo_data,
   output logic                 ofifo_rd,
   output logic [pBITS-1:0]     odata,
   output logic                 ovalid,
   input  logic                 iready,
   output logic                 osop,
   output logic                 oeop,
   output logic                 obusy,
   output logic [pCNT_BITS-1:0] opkt_cnt,
   output logic [pCNT_BITS-1:0] ozero_cnt
);

   generate
      if (pLEN_BITS > pBITS) begin : g_len_check
         $error("fifo_pkt_reader: pLEN_BITS must not exceed pBITS");
      end
      if (pBITS > HDR_MAX_BITS) begin : g_width_check
         $error("fifo_pkt_reader: pBITS exceeds HDR_MAX_BITS");
      end
   endgenerate

   state_t               state, state_nxt;
   logic [pLEN_BITS-1:0] rem;
   logic                 first;
   logic [pLEN_BITS-1:0] len;
   logic                 rd;
   logic                 load;
   logic                 slot_free;
   logic                 last_word;

   assign len       = pLEN_BITS'(hdr_len(HDR_MAX_BITS'(ififo_data), pLEN_BITS));
   assign last_word = (rem == pLEN_BITS'(1));
   assign ofifo_rd  = rd & ~ireset;
   assign obusy     = (state == ST_PAYLOAD);

   always_comb begin
      state_nxt = state;
      rd        = 1'b0;
      load      = 1'b0;
      unique case (state)
         ST_HDR: begin
            // Header pop ignores iready: it never reaches the stream.
            if (!ififo_empty) begin
               rd = 1'b1;
               if (len != '0) state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!ififo_empty && slot_free) begin
               rd   = 1'b1;
               load = 1'b1;
               if (last_word) state_nxt = ST_HDR;
            end
         end
         default: state_nxt = ST_HDR;
      endcase
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state     <= ST_HDR;
         rem       <= '0;
         first     <= 1'b0;
         opkt_cnt  <= '0;
         ozero_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_HDR && rd) begin
            if (len == '0) begin
               ozero_cnt <= ozero_cnt + pCNT_BITS'(1);
            end else begin
               rem   <= len;
               first <= 1'b1;
            end
         end
         if (load) begin
            rem   <= rem - pLEN_BITS'(1);
            first <= 1'b0;
         end
         if (ovalid && iready && oeop) opkt_cnt <= opkt_cnt + pCNT_BITS'(1);
      end
   end

   stream_reg_slice #(
      .pBITS (pBITS)
   ) u_out (
      .iclk      (iclk),
      .ireset    (ireset),
      .load      (load),
      .load_data (ififo_data),
      .load_sop  (first),
      .load_eop  (last_word),
      .ready     (iready),
      .data      (odata),
      .valid     (ovalid),
      .sop       (osop),
      .eop       (oeop),
      .slot_free (slot_free)
   );

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
//------------------------------------------------------------------------------
// tb_fifo_pkt_reader: directed self-checking bench for fifo_pkt_reader
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_pkt_reader;

   localparam int BITS     = 8;
   localparam int LEN_BITS = 8;
   localparam int CNT_BITS = 16;
   localparam int DEPTH    = 1024;

   logic                iclk   = 1'b0;
   logic                ireset = 1'b1;
   logic                iready = 1'b1;
   logic                ififo_empty;
   logic [BITS-1:0]     ififo_data;
   logic                ofifo_rd;
   logic [BITS-1:0]     odata;
   logic                ovalid;
   logic                osop;
   logic                oeop;
   logic                obusy;
   logic [CNT_BITS-1:0] opkt_cnt;
   logic [CNT_BITS-1:0] ozero_cnt;

   logic [BITS-1:0] mem [DEPTH];
   int              wr_ptr = 0;
   int              rd_ptr = 0;
   logic            flush  = 1'b0;

   logic [BITS-1:0] log_data [DEPTH];
   logic [1:0]      log_fr   [DEPTH];
   int              log_cyc  [DEPTH];
   int              n_acc  = 0;
   int              cyc    = 0;
   int              rd_cnt = 0;
   int              vld_cnt = 0;

   int vectors     = 0;
   int miscompares = 0;

   fifo_pkt_reader #(
      .pBITS     (BITS),
      .pLEN_BITS (LEN_BITS),
      .pCNT_BITS (CNT_BITS)
   ) dut (
      .iclk        (iclk),
      .ireset      (ireset),
      .ififo_empty (ififo_empty),
      .ififo_data  (ififo_data),
      .ofifo_rd    (ofifo_rd),
      .odata       (odata),
      .ovalid      (ovalid),
      .iready      (iready),
      .osop        (osop),
      .oeop        (oeop),
      .obusy       (obusy),
      .opkt_cnt    (opkt_cnt),
      .ozero_cnt   (ozero_cnt)
   );

   always #5 iclk = ~iclk;

   assign ififo_empty = (rd_ptr == wr_ptr);
   assign ififo_data  = mem[rd_ptr % DEPTH];

   // Show-ahead FIFO model, stream logger and protocol monitors.
   always @(posedge iclk) begin
      cyc <= cyc + 1;
      if (flush)                        rd_ptr <= wr_ptr;
      else if (ofifo_rd && !ififo_empty) rd_ptr <= rd_ptr + 1;
      if (ofifo_rd) rd_cnt  <= rd_cnt + 1;
      if (ovalid)   vld_cnt <= vld_cnt + 1;
      if (ovalid && iready) begin
         log_data[n_acc % DEPTH] <= odata;
         log_fr[n_acc % DEPTH]   <= {osop, oeop};
         log_cyc[n_acc % DEPTH]  <= cyc;
         n_acc <= n_acc + 1;
      end
      assert (!(ofifo_rd && ififo_empty)) else begin
         miscompares = miscompares + 1;
         $error("FAIL pop_on_empty observed=1 expected=0");
      end
      assert (!(obusy && ovalid && !iready && ofifo_rd)) else begin
         miscompares = miscompares + 1;
         $error("FAIL pop_while_stalled observed=1 expected=0");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [BITS-1:0] w);
      mem[wr_ptr % DEPTH] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      @(negedge iclk);
      while (!(rd_ptr == wr_ptr && !ovalid && !obusy) && k < 3000) begin
         @(negedge iclk);
         k++;
      end
      check({tag, "_timeout"}, 32'(k < 3000), 32'd1);
   endtask

   task automatic check_word(input string tag, input int idx,
                             input logic [BITS-1:0] d, input logic [1:0] fr);
      check({tag, "_data"}, 32'(log_data[idx % DEPTH]), 32'(d));
      check({tag, "_sopeop"}, 32'(log_fr[idx % DEPTH]), 32'(fr));
   endtask

   initial begin
      int b;
      int r;
      int v;
      int k;

      // Reset state, with a packet already waiting in the FIFO.
      push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
      repeat (3) @(negedge iclk);
      check("rst_ovalid", 32'(ovalid), 32'd0);
      check("rst_sopeop", 32'({osop, oeop}), 32'd0);
      check("rst_odata", 32'(odata), 32'd0);
      check("rst_rd_gated", 32'(ofifo_rd), 32'd0);
      check("rst_busy", 32'(obusy), 32'd0);
      check("rst_cnts", 32'({opkt_cnt, ozero_cnt}), 32'd0);

      // [3,A1,A2,A3] with iready high.
      b = n_acc; r = rd_cnt;
      ireset = 1'b0;
      wait_idle("pktA");
      check("pktA_count", 32'(n_acc - b), 32'd3);
      check_word("pktA_w0", b,     8'hA1, 2'b10);
      check_word("pktA_w1", b + 1, 8'hA2, 2'b00);
      check_word("pktA_w2", b + 2, 8'hA3, 2'b01);
      check("pktA_back2back", 32'(log_cyc[(b + 2) % DEPTH] - log_cyc[b % DEPTH]), 32'd2);
      check("pktA_rd_pulses", 32'(rd_cnt - r), 32'd4);
      check("pktA_pkt_cnt", 32'(opkt_cnt), 32'd1);

      // [1,B1][2,C1,C2]: one bubble between packets.
      b = n_acc;
      push(8'h01); push(8'hB1); push(8'h02); push(8'hC1); push(8'hC2);
      wait_idle("pktBC");
      check("pktBC_count", 32'(n_acc - b), 32'd3);
      check_word("pktB_w0", b,     8'hB1, 2'b11);
      check_word("pktC_w0", b + 1, 8'hC1, 2'b10);
      check_word("pktC_w1", b + 2, 8'hC2, 2'b01);
      check("pktBC_bubble", 32'(log_cyc[(b + 1) % DEPTH] - log_cyc[b % DEPTH]), 32'd2);
      check("pktC_contig", 32'(log_cyc[(b + 2) % DEPTH] - log_cyc[(b + 1) % DEPTH]), 32'd1);
      check("pktBC_pkt_cnt", 32'(opkt_cnt), 32'd3);

      // [0][1,D1]: zero-length header produces nothing on the stream.
      b = n_acc; v = vld_cnt;
      push(8'h00); push(8'h01); push(8'hD1);
      wait_idle("pktD");
      check("pktD_zero_cnt", 32'(ozero_cnt), 32'd1);
      check("pktD_count", 32'(n_acc - b), 32'd1);
      check_word("pktD_w0", b, 8'hD1, 2'b11);
      check("pktD_valid_cycles", 32'(vld_cnt - v), 32'd1);
      check("pktD_pkt_cnt", 32'(opkt_cnt), 32'd4);

      // [4,E1..E4] with iready toggling 1,0,0,1.
      b = n_acc;
      push(8'h04); push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
      for (int i = 0; i < 24; i++) begin
         @(negedge iclk);
         iready = ((i % 4) == 0) || ((i % 4) == 3);
      end
      @(negedge iclk);
      iready = 1'b1;
      wait_idle("pktE");
      check("pktE_count", 32'(n_acc - b), 32'd4);
      check_word("pktE_w0", b,     8'hE1, 2'b10);
      check_word("pktE_w1", b + 1, 8'hE2, 2'b00);
      check_word("pktE_w2", b + 2, 8'hE3, 2'b00);
      check_word("pktE_w3", b + 3, 8'hE4, 2'b01);
      check("pktE_pkt_cnt", 32'(opkt_cnt), 32'd5);

      // FIFO runs dry after the second of four payload words.
      b = n_acc;
      push(8'h04); push(8'h61); push(8'h62);
      k = 0;
      while (rd_ptr != wr_ptr && k < 100) begin @(negedge iclk); k++; end
      check("dry_drain_timeout", 32'(k < 100), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge iclk);
         check("dry_busy", 32'(obusy), 32'd1);
      end
      check("dry_bubble_valid", 32'(ovalid), 32'd0);
      check("dry_accepted", 32'(n_acc - b), 32'd2);
      push(8'h63); push(8'h64);
      wait_idle("dry");
      check("dry_count", 32'(n_acc - b), 32'd4);
      check_word("dry_w0", b,     8'h61, 2'b10);
      check_word("dry_w1", b + 1, 8'h62, 2'b00);
      check_word("dry_w2", b + 2, 8'h63, 2'b00);
      check_word("dry_w3", b + 3, 8'h64, 2'b01);
      check("dry_pkt_cnt", 32'(opkt_cnt), 32'd6);

      // Maximum length header L=255.
      b = n_acc;
      push(8'hFF);
      for (int i = 1; i <= 255; i++) push(8'(i));
      wait_idle("max");
      check("max_count", 32'(n_acc - b), 32'd255);
      check_word("max_first", b,       8'h01, 2'b10);
      check_word("max_mid",   b + 100, 8'h65, 2'b00);
      check_word("max_last",  b + 254, 8'hFF, 2'b01);
      check("max_span", 32'(log_cyc[(b + 254) % DEPTH] - log_cyc[b % DEPTH]), 32'd254);
      check("max_pkt_cnt", 32'(opkt_cnt), 32'd7);

      // Reset pulse partway through a 5-word packet.
      b = n_acc;
      push(8'h05); push(8'h71); push(8'h72); push(8'h73); push(8'h74); push(8'h75);
      k = 0;
      while ((n_acc - b) < 2 && k < 100) begin @(negedge iclk); k++; end
      check("rstmid_wait_timeout", 32'(k < 100), 32'd1);
      ireset = 1'b1;
      #1;
      check("rstmid_ovalid", 32'(ovalid), 32'd0);
      check("rstmid_sopeop", 32'({osop, oeop}), 32'd0);
      check("rstmid_odata", 32'(odata), 32'd0);
      check("rstmid_busy", 32'(obusy), 32'd0);
      check("rstmid_rd", 32'(ofifo_rd), 32'd0);
      check("rstmid_cnts", 32'({opkt_cnt, ozero_cnt}), 32'd0);
      flush = 1'b1;
      @(negedge iclk);
      flush  = 1'b0;
      ireset = 1'b0;
      b = n_acc;
      push(8'h01); push(8'hF1);
      wait_idle("pktF");
      check("pktF_count", 32'(n_acc - b), 32'd1);
      check_word("pktF_w0", b, 8'hF1, 2'b11);
      check("pktF_pkt_cnt", 32'(opkt_cnt), 32'd1);
      check("pktF_zero_cnt", 32'(ozero_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
